// File: rtl/alu_seq_muldiv.sv
// Registered EX-stage ALU with iterative shift-add multiply and restoring divide writing HI/LO.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise DIV/DIVU behave as illegal opcodes.
module alu_seq_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [3:0]       alucontrol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_output,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if_wide(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    state_t             state;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               neg_lo_q;

    logic               is_mul, is_div, op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH:0]     add_w, sub_w;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_carry, sc_ovf;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign is_mul    = (alucontrol == OP_MULT) || (alucontrol == OP_MULTU);
    assign op_signed = (alucontrol == OP_MULT) || (alucontrol == OP_DIV);
    assign a_mag     = neg_if(srcA, op_signed & srcA[WIDTH-1]);
    assign b_mag     = neg_if(srcB, op_signed & srcB[WIDTH-1]);
    assign a_s       = srcA;
    assign b_s       = srcB;

`ifdef ALU_SEQ_DIV_EN
    logic               op_div_q, dbz_q, neg_hi_q;
    logic               b_zero;
    logic [WIDTH:0]     div_top, div_diff;
    logic [2*WIDTH-1:0] div_next;

    assign is_div   = (alucontrol == OP_DIV) || (alucontrol == OP_DIVU);
    assign b_zero   = (srcB == '0);
    // Restoring step: shift the next dividend bit into the partial remainder, keep it if it fits.
    assign div_top  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_diff = div_top - {1'b0, divisor_q};
    assign div_next = div_diff[WIDTH] ? {div_top[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
`else
    assign is_div   = 1'b0;
`endif

    // Shift-add step: conditionally add the multiplicand into the upper half, then shift right.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, divisor_q} : '0);
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    assign mul_fix  = neg_if_wide(prod_q, neg_lo_q);

    always_comb begin
        fix_hi = mul_fix[2*WIDTH-1:WIDTH];
        fix_lo = mul_fix[WIDTH-1:0];
`ifdef ALU_SEQ_DIV_EN
        if (op_div_q) begin
            fix_hi = neg_if(prod_q[2*WIDTH-1:WIDTH], neg_hi_q);
            fix_lo = neg_if(prod_q[WIDTH-1:0], neg_lo_q);
        end
`endif
    end

    assign add_w = {1'b0, srcA} + {1'b0, srcB};
    assign sub_w = {1'b0, srcA} + {1'b0, ~srcB} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (alucontrol)
            OP_AND:  sc_res = srcA & srcB;
            OP_OR:   sc_res = srcA | srcB;
            OP_XOR:  sc_res = srcA ^ srcB;
            OP_NOR:  sc_res = ~(srcA | srcB);
            OP_ADD: begin
                sc_res   = add_w[WIDTH-1:0];
                sc_carry = add_w[WIDTH];
                sc_ovf   = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (add_w[WIDTH-1] != srcA[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = sub_w[WIDTH-1:0];
                sc_carry = sub_w[WIDTH];
                sc_ovf   = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (sub_w[WIDTH-1] != srcA[WIDTH-1]);
            end
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
            default: sc_res = '0;
        endcase
    end

    assign zero = (alu_output == '0);

    // Iteration datapath: loaded on accept, stepped once per ITER cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
`ifdef ALU_SEQ_DIV_EN
            op_div_q <= is_div;
            dbz_q    <= is_div && b_zero;
            neg_hi_q <= op_signed && srcA[WIDTH-1] && !b_zero;
            if (is_div) begin
                divisor_q <= b_mag;
                prod_q    <= b_zero ? {srcA, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a_mag};
                neg_lo_q  <= op_signed && (srcA[WIDTH-1] ^ srcB[WIDTH-1]) && !b_zero;
            end else
`endif
            begin
                divisor_q <= a_mag;
                prod_q    <= {{WIDTH{1'b0}}, b_mag};
                neg_lo_q  <= op_signed && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
            end
        end else if (state == ITER) begin
`ifdef ALU_SEQ_DIV_EN
            prod_q <= op_div_q ? div_next : mul_next;
`else
            prod_q <= mul_next;
`endif
        end
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt_q       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            alu_output  <= '0;
            carry_out   <= 1'b0;
            overflow    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        cnt_q    <= CNT_W'(WIDTH - 1);
                        if (is_mul) begin
                            state <= ITER;
                        end else if (is_div) begin
`ifdef ALU_SEQ_DIV_EN
                            state <= b_zero ? FIX : ITER;
`else
                            state <= ITER;
`endif
                        end else begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            alu_output  <= sc_res;
                            carry_out   <= sc_carry;
                            overflow    <= sc_ovf;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    if (cnt_q == '0) state <= FIX;
                    else             cnt_q <= cnt_q - 1'b1;
                end
                FIX: begin
                    state      <= DONE;
                    out_valid  <= 1'b1;
                    hi         <= fix_hi;
                    lo         <= fix_lo;
                    alu_output <= fix_lo;
                    carry_out  <= 1'b0;
                    overflow   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
                    div_by_zero <= dbz_q;
`else
                    div_by_zero <= 1'b0;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU for the MIPS32 core.
- Adds signed/unsigned compare, XOR/NOR and overflow detection.
- Adds iterative multi-cycle MULT/MULTU/DIV/DIVU writing HI/LO.
- Sits in the EX stage behind a valid/ready handshake, so the pipeline stalls on busy.

Parameters:
- WIDTH, 32, datapath width in bits (even, >=8).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept an operation
- srcA  input  WIDTH  operand A
- srcB  input  WIDTH  operand B
- alucontrol  input  4  operation select
- out_valid  output  1  result valid, held until out_ready
- out_ready  input  1  consumer accepts result
- alu_output  output  WIDTH  registered result (LO for mul/div)
- zero  output  1  alu_output == 0
- carry_out  output  1  carry (add) / NOT borrow (sub)
- overflow  output  1  signed overflow (add/sub)
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- div_by_zero  output  1  last DIV/DIVU had srcB == 0

Behaviour:
- Async reset (reset_n=0): the following outputs/regs are 0: state=IDLE, in_ready=1, out_valid, alu_output, carry_out, overflow, hi, lo, div_by_zero. zero reads 1.
- Opcodes:
  - 0000 AND, 0001 OR, 0100 XOR, 0101 NOR
  - 0010 ADD, 0110 SUB
  - 0111 SLT (signed), 0011 SLTU
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU
  - Others are illegal: result 0, carry/overflow 0, single-cycle.
- Accept: in_valid & in_ready on a clock edge. Operands and opcode are captured; in_ready drops to 0 the same edge.
- States: IDLE -> (single-cycle op) DONE; IDLE -> (mul/div) ITER -> FIX -> DONE; DONE -> (out_ready) IDLE.
- Single-cycle ops: out_valid=1 on the edge after accept, i.e. latency 1.
- ADD/SUB: computed as WIDTH+1 bits. carry_out = bit WIDTH (SUB: 1 means no borrow). overflow = sign rule on operands and result.
- Logic ops leave carry_out/overflow at 0. SLT/SLTU output 1 or 0, zero-extended.
- MULT/MULTU: shift-add, one bit per cycle, WIDTH cycles in ITER.
  - Signed ops take magnitudes on accept; FIX applies the sign.
  - out_valid is asserted WIDTH+2 cycles after accept.
  - {hi,lo} = full 2*WIDTH product; alu_output = lo.
- DIV/DIVU: restoring divide, WIDTH cycles in ITER, same WIDTH+2 latency.
  - lo = quotient, truncated toward zero.
  - hi = remainder, with the sign of the dividend.
- srcB == 0 on a divide: skip ITER, FIX on the next cycle (latency 2). lo = all ones, hi = srcA, div_by_zero=1. Any other op clears div_by_zero at DONE.
- Signed divide, srcA = most-negative and srcB = -1: lo = most-negative, hi = 0, overflow=0.
- hi/lo update only at FIX entry to DONE for mul/div; other ops leave hi/lo unchanged.
- zero is combinational from alu_output.
- DONE holds all outputs stable until out_ready.
- out_ready asserted in DONE: out_valid falls and in_ready rises on the same edge. There is no back-to-back accept in that cycle, so throughput is at most one op per 2 cycles.
- in_valid is ignored while in_ready=0; operands need not be held after accept.
- Reset mid-ITER aborts immediately to the reset values; partial hi/lo are discarded.

Optional Feature:
- Macro ALU_SEQ_DIV_EN.
- Defined: DIV/DIVU are implemented as specified above.
- Undefined: the divider datapath is not compiled. DIV/DIVU are treated as illegal opcodes:
  - result 0, latency 1;
  - hi/lo unchanged;
  - div_by_zero stays 0.

Test Plan:
- ADD 0xFFFFFFFF + 0x00000001 (WIDTH=32) -> alu_output=0, zero=1, carry_out=1, overflow=0, out_valid 1 cycle after accept.
- ADD 0x7FFFFFFF + 1 -> 0x80000000, overflow=1. SLT -1 vs 1 -> 1. SLTU 0xFFFFFFFF vs 1 -> 0.
- MULT 0xFFFFFFFE (-2) x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, out_valid exactly 34 cycles after accept, in_ready=0 throughout.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1, latency 2.
- Hold out_ready=0 for 5 cycles after AND 0xF0F0 & 0xFF00 -> alu_output=0xF000 held stable, new in_valid ignored. out_ready=1 -> out_valid falls and in_ready rises on the next edge.
- Assert reset_n=0 at cycle 10 of a MULTU -> all outputs 0 at once. After release, ADD 2+3 -> 5 and hi/lo = 0.
